// File: rtl/fifo_rd_packer.sv
// Read-side byte packer: pops bytes from the async FIFO and assembles BYTES-wide
// words with a keep mask, presented on a valid/ready handshake with flush support.
module fifo_rd_packer #(
  parameter int BYTES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk_read,
  input  logic                 rst,
  input  logic                 empty,
  input  logic [7:0]           fifo_data,
  input  logic                 flush,
  output logic                 read_enable,
  output logic [8*BYTES-1:0]   word_out,
  output logic [BYTES-1:0]     word_keep,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [CNT_W-1:0]     words_out
);

  localparam int IDX_W = $clog2(BYTES) + 1;
  localparam logic [IDX_W:0] BYTES_L = (IDX_W+1)'(BYTES);

  typedef enum logic {FILL, OUT} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     byte_idx_q;
  logic                 rd_pending_q;
  logic                 flush_req_q;
  logic                 flushed_q;
  logic [8*BYTES-1:0]   word_q;
  logic [BYTES-1:0]     keep_q;
  logic [CNT_W-1:0]     words_q;
  logic [IDX_W:0]       fill_d;

  // Bytes captured plus the one in flight must leave room for another pop.
  assign fill_d = {1'b0, byte_idx_q} + {{IDX_W{1'b0}}, rd_pending_q};

  assign read_enable = !rst && (state_q == FILL) && !empty && !flush_req_q &&
                       (fill_d < BYTES_L);

  always_ff @(posedge clk_read) begin
    if (rst) begin
      state_q      <= FILL;
      byte_idx_q   <= '0;
      rd_pending_q <= 1'b0;
      flush_req_q  <= 1'b0;
      flushed_q    <= 1'b0;
      word_q       <= '0;
      keep_q       <= '0;
      words_q      <= '0;
    end else begin
      rd_pending_q <= read_enable && !empty;
      flush_req_q  <= flush_req_q || flush;
      case (state_q)
        FILL: begin
          if (rd_pending_q) begin
            for (int i = 0; i < BYTES; i++) begin
              if (byte_idx_q == IDX_W'(i)) begin
                word_q[i*8 +: 8] <= fifo_data;
                keep_q[i]        <= 1'b1;
              end
            end
            byte_idx_q <= byte_idx_q + IDX_W'(1);
            if (byte_idx_q == IDX_W'(BYTES-1)) begin
              state_q   <= OUT;
              flushed_q <= 1'b0;
            end
          end else if (flush_req_q) begin
            // A flush with nothing held resolves silently; otherwise it emits a partial word.
            if (byte_idx_q != '0) begin
              state_q   <= OUT;
              flushed_q <= 1'b1;
            end else begin
              flush_req_q <= flush;
            end
          end
        end
        OUT: begin
          if (word_ready) begin
            state_q    <= FILL;
            byte_idx_q <= '0;
            word_q     <= '0;
            keep_q     <= '0;
            words_q    <= words_q + CNT_W'(1);
            flushed_q  <= 1'b0;
            if (flushed_q) flush_req_q <= flush;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign word_out   = word_q;
  assign word_keep  = keep_q;
  assign word_valid = (state_q == OUT);
  assign words_out  = words_q;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer that sits directly downstream of the async FIFO in the `clk_read` domain. It pops bytes from the FIFO read port and packs them into `BYTES`-wide words with a byte-keep mask. It presents each word on a valid/ready handshake to the next stage and supports a flush that emits a partial word. Its reset is shared with the FIFO's `rst`.

## Interface
- `BYTES`, default 4: bytes per output word; must be ≥2.
- `CNT_W`, default 16: width of the delivered-word counter.
- `clk_read`  in  1  read-domain clock; all state on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `empty`  in  1  FIFO empty flag.
- `fifo_data`  in  8  FIFO `data_out`; registered and valid the cycle after a sampled pop.
- `flush`  in  1  one-cycle request to emit the current partial word.
- `read_enable`  out  1  FIFO pop request, combinational.
- `word_out`  out  8*BYTES  packed word; lane 0 is bits 7:0 and holds the oldest byte.
- `word_keep`  out  BYTES  per-lane valid mask.
- `word_valid`  out  1  output word available.
- `word_ready`  in  1  downstream accepts the word.
- `words_out`  out  CNT_W  count of accepted words; wraps modulo 2^CNT_W.

## Operation
- States: FILL (collecting bytes) and OUT (holding the word until it is accepted).
- Internal registers:
  - `byte_idx`, width clog2(BYTES)+1: number of bytes captured.
  - `rd_pending`: a pop was sampled last edge.
  - `flush_req`: latched flush.
- `read_enable` is high only when all of the following hold: state is FILL, `!empty`, `!flush_req`, and `byte_idx + rd_pending < BYTES`.
  - It is never high in OUT or during reset.
- Each edge, `rd_pending <= read_enable && !empty`.
- When `rd_pending` is 1 at an edge:
  - `fifo_data` is written into lane `byte_idx`.
  - `byte_idx` increments.
  - That lane's keep bit is set.
- FILL→OUT when either:
  - a capture makes `byte_idx == BYTES` (keep is all-ones), or
  - `flush_req` is set, `rd_pending == 0`, and `byte_idx > 0`. Lanes ≥ `byte_idx` read 0 with keep 0.
- Flush with nothing held: `flush_req` set, `rd_pending == 0`, and `byte_idx == 0` → `flush_req` clears, no word is produced, and the block stays in FILL.
- `flush` is sampled every cycle into `flush_req`. It is held until the flush resolves, including across OUT.
  - A flush arriving while in OUT applies to the next word.
- In OUT, `word_out`/`word_keep`/`word_valid` are stable until `word_valid && word_ready` at an edge. On that edge:
  - return to FILL;
  - `byte_idx`, `word_out`, and `word_keep` clear to 0;
  - `words_out` increments;
  - if the word was produced by a flush, `flush_req` clears.
- `word_valid` does not depend combinationally on `word_ready`.
- Bytes are never dropped or reordered. The block never pops while `empty` is 1.

## Timing
- Reset values: FILL; `byte_idx` = 0; `rd_pending` = 0; `flush_req` = 0; `word_out` = 0; `word_keep` = 0; `word_valid` = 0; `words_out` = 0; `read_enable` = 0.
- Reset mid-operation: a byte popped in the cycle before reset is discarded. Both blocks must see the same `rst`.
- Pop-to-capture latency is 1 cycle, and back-to-back pops are allowed.
- With the FIFO continuously non-empty, `BYTES` = 4:
  - pops in cycles 0–3;
  - captures at the ends of cycles 1–4;
  - `word_valid` high in cycle 5 (latency `BYTES` + 1).
- Sustained throughput is one word per `BYTES` + 2 cycles when `word_ready` is held high, because there are no pops during OUT.
- `empty` rising mid-word stalls popping. Any pending capture still completes, and captured bytes are kept.
- `flush` and a pending capture in the same cycle: the capture lands first, and the flush resolves on the next edge.

## Test plan
- Push 0x11,0x22,0x33,0x44 with `word_ready` = 1 → `word_out` = 0x44332211, `word_keep` = 0xF, `word_valid` high in cycle 5 after the first pop, `words_out` = 1.
- Push 8 bytes 0x01..0x08 with `word_ready` low for 10 cycles → `read_enable` stays 0 in OUT, word 0x04030201 held stable, then 0x08070605; `words_out` = 2.
- Push 0xAA,0xBB then pulse `flush` → `word_out` = 0x0000BBAA, `word_keep` = 0x3; `flush` with an empty packer → no `word_valid`, and `flush_req` clears.
- Pulse `flush` in the same cycle `rd_pending` = 1 for the 3rd byte (0x11,0x22,0x33) → single word 0x00332211, keep 0x7, no byte lost.
- Assert `rst` with 2 bytes captured and `word_valid` = 0 → all outputs return to reset values the next cycle, `read_enable` = 0 during reset.
- Run 65,537 words → `words_out` wraps to 1; `read_enable` never coincides with `empty` = 1.
